// File: rtl/table_port_arbiter.sv
// table_port_arbiter
//   Shares one port of a single-clock table memory (1-cycle registered read)
//   among NUM_REQ requesters. Round-robin arbitration with a bounded burst
//   hold, a registered command stage towards the memory, and read-response
//   routing back to the requester that issued the read.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   arb_en            1 = arbitrate, 0 = no new accepts (in-flight ops finish)
//   req_vld/req_rdy   per-requester handshake, req_rdy one-hot or zero
//   req_we            per-requester write flag (0 = read)
//   req_addr          packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata         packed write data, requester i at [i*DATA_W +: DATA_W]
//   rsp_vld           one-hot read-data valid, 2 cycles after the read accept
//   rsp_data          read data shared by all requesters
//   mem_en/mem_we     memory enable / write enable
//   mem_addr/wdata    memory address / write data
//   mem_rdata         memory read data, valid 1 cycle after a read command
//   busy              command or read response in flight
module table_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arb_en,
    input  logic [NUM_REQ-1:0]          req_vld,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_vld,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);
    localparam logic [OW-1:0] LAST_REQ = OW'(NUM_REQ - 1);

    logic [OW-1:0] owner;
    logic [3:0]    burst_cnt;
    logic [OW-1:0] grant;
    logic          grant_vld;

    logic          p0_vld;
    logic [OW-1:0] p0_id;
    logic          p1_vld;
    logic [OW-1:0] p1_id;

    // burst_cnt == 0 means no burst is in progress (after reset or an idle
    // cycle), so the search starts one past the owner. A lone valid owner is
    // still found because the search wraps back onto it last.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant     = owner;
        idx       = 0;
        if (arb_en) begin
            if (req_vld[owner] && (burst_cnt != 4'd0) && (burst_cnt < MAX_B)) begin
                grant_vld = 1'b1;
                grant     = owner;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (int'(owner) + k) % NUM_REQ;
                    if (!grant_vld && req_vld[idx]) begin
                        grant_vld = 1'b1;
                        grant     = OW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (grant_vld) begin
            req_rdy[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= LAST_REQ;
            burst_cnt <= 4'd0;
        end else if (grant_vld) begin
            if (grant == owner && burst_cnt != 4'd0) begin
                burst_cnt <= (burst_cnt < MAX_B) ? burst_cnt + 4'd1 : MAX_B;
            end else begin
                owner     <= grant;
                burst_cnt <= 4'd1;
            end
        end else begin
            burst_cnt <= 4'd0;
        end
    end

    // Command stage: address and data hold their last values when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_vld) begin
            mem_en    <= 1'b1;
            mem_we    <= req_we[grant];
            mem_addr  <= req_addr[int'(grant)*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[int'(grant)*DATA_W +: DATA_W];
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Read pipeline: stage 0 lines up with the memory command, stage 1 with
    // the memory's registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_vld <= 1'b0;
            p0_id  <= '0;
            p1_vld <= 1'b0;
            p1_id  <= '0;
        end else begin
            p0_vld <= grant_vld && !req_we[grant];
            p0_id  <= grant;
            p1_vld <= p0_vld;
            p1_id  <= p0_id;
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (p1_vld) begin
            rsp_vld[p1_id] = 1'b1;
        end
    end

    assign rsp_data = mem_rdata;
    assign busy     = mem_en | p0_vld | p1_vld;

endmodule
